// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesting masters, the arbiter and the shared memory port.
// The arbiter takes the slave view; the environment (masters + memory) takes the master view.
interface mem_arbiter_if;
  logic [19:0] p0_addr;
  logic        p0_byte_m;
  logic        p0_op;
  logic [15:0] p0_rd_data;
  logic        p0_ready;

  logic [19:0] p1_addr;
  logic        p1_byte_m;
  logic        p1_op;
  logic [15:0] p1_rd_data;
  logic        p1_ready;

  logic [19:0] mem_addr;
  logic        mem_byte_m;
  logic        mem_op;
  logic [15:0] mem_rd_data;
  logic        mem_ready;

  logic        timeout_err;

  modport slave (
    input  p0_addr, p0_byte_m, p0_op,
    input  p1_addr, p1_byte_m, p1_op,
    input  mem_rd_data, mem_ready,
    output p0_rd_data, p0_ready,
    output p1_rd_data, p1_ready,
    output mem_addr, mem_byte_m, mem_op,
    output timeout_err
  );

  modport master (
    output p0_addr, p0_byte_m, p0_op,
    output p1_addr, p1_byte_m, p1_op,
    output mem_rd_data, mem_ready,
    input  p0_rd_data, p0_ready,
    input  p1_rd_data, p1_ready,
    input  mem_addr, mem_byte_m, mem_op,
    input  timeout_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: grants one master per transaction, drives the shared mem_op/ready
// handshake, returns read data with a one-cycle acknowledge and aborts stalled accesses.
module mem_arbiter #(
  parameter bit PRIO0   = 1'b0,
  parameter int TIMEOUT = 255
) (
  input  logic         cpu_clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic        r_grant;
  logic        r_last;
  logic [19:0] r_mem_addr;
  logic        r_mem_byte_m;
  logic        r_mem_op;
  logic [15:0] r_p0_rd_data;
  logic [15:0] r_p1_rd_data;
  logic        r_p0_ready;
  logic        r_p1_ready;
  logic        r_timeout_err;

  logic        w_req;
  logic        w_win;
  logic        w_finish;
  logic [15:0] w_rd_data;

  assign w_req = bus.p0_op | bus.p1_op;

  // On a tie the fixed-priority build always picks port 0; otherwise the port not granted last.
  assign w_win = (bus.p0_op & bus.p1_op) ? (PRIO0 ? 1'b0 : ~r_last) : bus.p1_op;

  // A WAIT cycle ends on memory completion or on the last permitted cycle of the watchdog.
  assign w_finish  = bus.mem_ready | (r_cnt == CNT_LAST);
  assign w_rd_data = bus.mem_ready ? bus.mem_rd_data : 16'hFFFF;

  // NOTE: every register here is state, so all assignments are non-blocking; there is no
  // storage array, so the synchronous reset can cover every flop including the data holders.
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= 8'd0;
      r_grant       <= 1'b0;
      r_last        <= 1'b1;
      r_mem_addr    <= 20'd0;
      r_mem_byte_m  <= 1'b0;
      r_mem_op      <= 1'b0;
      r_p0_rd_data  <= 16'd0;
      r_p1_rd_data  <= 16'd0;
      r_p0_ready    <= 1'b0;
      r_p1_ready    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      // NOTE: the acknowledges default low each cycle so they can only ever pulse for one cycle.
      r_p0_ready <= 1'b0;
      r_p1_ready <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_grant      <= w_win;
            r_last       <= w_win;
            r_mem_addr   <= w_win ? bus.p1_addr   : bus.p0_addr;
            r_mem_byte_m <= w_win ? bus.p1_byte_m : bus.p0_byte_m;
            r_mem_op     <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end

        // mem_ready is deliberately not looked at here: it may still be high from the last access.
        S_ISSUE: begin
          r_cnt   <= 8'd0;
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          if (!bus.mem_ready) begin
            r_cnt <= r_cnt + 8'd1;
          end
          if (w_finish) begin
            r_mem_op <= 1'b0;
            r_state  <= S_DONE;
            if (r_grant) begin
              r_p1_rd_data <= w_rd_data;
              r_p1_ready   <= 1'b1;
            end else begin
              r_p0_rd_data <= w_rd_data;
              r_p0_ready   <= 1'b1;
            end
            if (!bus.mem_ready) begin
              r_timeout_err <= 1'b1;
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_byte_m  = r_mem_byte_m;
  assign bus.mem_op      = r_mem_op;
  assign bus.p0_rd_data  = r_p0_rd_data;
  assign bus.p0_ready    = r_p0_ready;
  assign bus.p1_rd_data  = r_p1_rd_data;
  assign bus.p1_ready    = r_p1_ready;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single memory request port (ROM/RAM decode, flash controller behind it) between the CPU bus (port 0) and a secondary master such as a display or DMA fetch unit (port 1). It selects one requester and latches that requester's address and byte mode. It drives the shared `mem_op`/`ready` handshake, returns read data to the winner with a one-cycle acknowledge, and aborts stalled transactions with a watchdog. The block sits between the masters and `memory`, in the `cpu_clk` domain.

## Interface
- `PRIO0`, default 0: 1 = port 0 always wins ties (fixed priority); 0 = round-robin.
- `TIMEOUT`, default 255: maximum WAIT cycles before abort; legal range 1..255 (8-bit counter).

- `cpu_clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `p0_addr`  in  20  port 0 byte address
- `p0_byte_m`  in  1  port 0 byte (1) / word (0) access
- `p0_op`  in  1  port 0 request; held high until `p0_ready`
- `p0_rd_data`  out  16  port 0 read data, valid while `p0_ready`=1, held afterwards
- `p0_ready`  out  1  port 0 one-cycle acknowledge
- `p1_addr`, `p1_byte_m`, `p1_op`, `p1_rd_data`, `p1_ready`: same definitions as port 0, for port 1
- `mem_addr`  out  20  address to memory
- `mem_byte_m`  out  1  byte mode to memory
- `mem_op`  out  1  memory request, level
- `mem_rd_data`  in  16  memory read data
- `mem_ready`  in  1  memory completion; may be constantly 1 for some address areas
- `timeout_err`  out  1  sticky; set on any watchdog abort, cleared only by reset

## Operation
- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE: `mem_op`=0. Requests are sampled only here.
  - No request: stay in IDLE.
  - Single request: that port wins.
  - Both requesting, `PRIO0`=1: port 0 wins.
  - Both requesting, `PRIO0`=0: the port not granted last wins.
  - On a win: latch the winner's addr/byte_m into `mem_addr`/`mem_byte_m`, record the grant, go to ISSUE.
- ISSUE: `mem_op`=1. `mem_ready` is ignored in this state, because a stale high may remain from the previous access. Clear the watchdog counter, go to WAIT.
- WAIT: `mem_op`=1.
  - `mem_ready`=1: capture `mem_rd_data` into the granted port's `rd_data`, go to DONE.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`, load 16'hFFFF into the granted port's `rd_data`, set `timeout_err`, and go to DONE.
- DONE: `mem_op`=0; the granted port's `pN_ready`=1 for exactly this cycle. Go to IDLE.
- Masters must drop or replace `pN_op` on the edge where they sample `pN_ready`=1. The following IDLE cycle sees the new request value, so a completed request is never double-served.
- `mem_addr`/`mem_byte_m` stay stable from ISSUE through DONE, and hold their last values in IDLE.
- The non-granted port's outputs do not change. Its request simply waits; it is not lost.
- Round-robin pointer: updates at every grant. After reset it points at port 1, so port 0 wins the first tie.
- The arbiter does not check for a request withdrawn mid-transaction. The latched transaction completes and is acknowledged anyway.

## Timing
- Reset values: state IDLE, `mem_op`=0, `mem_addr`=0, `mem_byte_m`=0, `p0_ready`=`p1_ready`=0, `p0_rd_data`=`p1_rd_data`=0, `timeout_err`=0, counter=0, last grant = port 1.
- Reset asserted mid-transaction: the next edge returns to IDLE and drops `mem_op`. No `pN_ready` is issued for the aborted access.
- Minimum latency with `mem_ready` held at 1:
  - Request present at edge 0 (IDLE).
  - ISSUE after edge 1; WAIT after edge 2, capturing data at edge 3.
  - `pN_ready`=1 in the cycle after edge 3.
  - Result: 4 cycles from request to acknowledge; sustained throughput of 1 transaction per 4 cycles.
- `mem_ready` first high k cycles into WAIT (k ≥ 0): acknowledge comes k cycles later than the minimum.
- Timeout: abort after `TIMEOUT` WAIT cycles without `mem_ready`; `pN_ready` follows in the next cycle.
- A `mem_ready` pulse arriving during DONE or IDLE is ignored.

## Test plan
- Single read, port 0: `p0_addr`=20'hF0010, `mem_ready`=1 constant, `mem_rd_data`=16'hBEEF → `mem_op` high for 2 cycles, `mem_addr`=F0010, `p0_ready` pulse 4 cycles after request, `p0_rd_data`=BEEF; port 1 outputs unchanged.
- Slow memory: `mem_ready` rises 5 cycles into WAIT, data 16'h1234 → ack 5 cycles later than minimum. A stale `mem_ready`=1 present during ISSUE must not complete the access early.
- Contention, `PRIO0`=0: both ports request continuously → grants alternate 0,1,0,1 with exactly one `pN_ready` every 4 cycles. Repeat with `PRIO0`=1 → port 0 is served every time and port 1 starves while port 0 holds its request.
- Watchdog: `TIMEOUT`=8, `mem_ready` stuck at 0 → `p1_ready` pulse after 8 WAIT cycles with `p1_rd_data`=16'hFFFF, `timeout_err`=1 and remaining 1 through later good accesses, cleared only by `reset`.
- Reset mid-WAIT: assert `reset` in the 2nd WAIT cycle → `mem_op`=0 at the next edge, no `pN_ready`, all outputs at reset values. After release, a port-0 vs port-1 tie grants port 0 first.
- Byte mode passthrough: port 1 with `p1_byte_m`=1, addr 20'hC0001 → `mem_byte_m`=1 and `mem_addr`=C0001 held stable from ISSUE through DONE.
